// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU codes,
// datapath select encodings, FSM states and opcode classification helpers.
package mips_ctrl_pkg;

    localparam int ALUCW = 6;
    localparam int SRCBW = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [ALUCW-1:0] ALU_ADD  = 6'b100000;
    localparam logic [ALUCW-1:0] ALU_ADDU = 6'b100001;
    localparam logic [ALUCW-1:0] ALU_SUB  = 6'b100010;
    localparam logic [ALUCW-1:0] ALU_AND  = 6'b100100;
    localparam logic [ALUCW-1:0] ALU_OR   = 6'b100101;
    localparam logic [ALUCW-1:0] ALU_XOR  = 6'b100110;
    localparam logic [ALUCW-1:0] ALU_SLT  = 6'b101010;
    localparam logic [ALUCW-1:0] ALU_SLTU = 6'b101011;

    localparam logic [SRCBW-1:0] SRCB_B    = 3'b000;
    localparam logic [SRCBW-1:0] SRCB_4    = 3'b001;
    localparam logic [SRCBW-1:0] SRCB_SIMM = 3'b010;
    localparam logic [SRCBW-1:0] SRCB_ZIMM = 3'b011;
    localparam logic [SRCBW-1:0] SRCB_LUI  = 3'b100;
    localparam logic [SRCBW-1:0] SRCB_BR   = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE, S_IMMEX, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_IDLE, CLS_FETCH, CLS_DECODE, CLS_ADDR, CLS_RTYPE, CLS_IMMEX, CLS_BRANCH
    } alu_class_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU) || (op == OP_LWU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI) || (op == OP_SLTIU) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic             en;
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             Zero;
    logic             mem_ack;
    logic             mem_req;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCEn;
    logic [1:0]       PCSrc;
    logic             ALUSrcA;
    logic [SRCBW-1:0] ALUSrcB;
    logic [ALUCW-1:0] ALUControl;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             trap;

    modport master (
        input  en, Op, Funct, Zero, mem_ack,
        output mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegDst, MemtoReg, RegWrite, trap
    );

    modport slave (
        output en, Op, Funct, Zero, mem_ack,
        input  mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegDst, MemtoReg, RegWrite, trap
    );
endinterface

// File: rtl/mips_alu_sel.sv
// Combinational ALU operation / ALUSrcB selection from the current state class
// and the instruction fields; also flags R-type funct codes the ALU supports.
module mips_alu_sel
    import mips_ctrl_pkg::*;
(
    input  alu_class_t       cls_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    output logic [ALUCW-1:0] alu_ctrl_o,
    output logic [SRCBW-1:0] srcb_o,
    output logic             funct_legal_o
);

    always_comb begin
        funct_legal_o = 1'b0;
        case (funct_i)
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_AND,
            ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU: funct_legal_o = 1'b1;
            default:                            funct_legal_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        srcb_o     = SRCB_B;
        case (cls_i)
            CLS_FETCH:  srcb_o = SRCB_4;
            CLS_DECODE: srcb_o = SRCB_BR;
            CLS_ADDR:   srcb_o = SRCB_SIMM;
            CLS_RTYPE:  alu_ctrl_o = funct_legal_o ? funct_i : ALU_ADD;
            CLS_BRANCH: alu_ctrl_o = ALU_SUB;
            CLS_IMMEX: begin
                // Logical immediates are zero-extended; LUI is OR with $0 and imm<<16.
                case (op_i)
                    OP_ADDI:  begin alu_ctrl_o = ALU_ADD;  srcb_o = SRCB_SIMM; end
                    OP_ADDIU: begin alu_ctrl_o = ALU_ADDU; srcb_o = SRCB_SIMM; end
                    OP_ANDI:  begin alu_ctrl_o = ALU_AND;  srcb_o = SRCB_ZIMM; end
                    OP_ORI:   begin alu_ctrl_o = ALU_OR;   srcb_o = SRCB_ZIMM; end
                    OP_XORI:  begin alu_ctrl_o = ALU_XOR;  srcb_o = SRCB_ZIMM; end
                    OP_SLTI:  begin alu_ctrl_o = ALU_SLT;  srcb_o = SRCB_SIMM; end
                    OP_SLTIU: begin alu_ctrl_o = ALU_SLTU; srcb_o = SRCB_SIMM; end
                    OP_LUI:   begin alu_ctrl_o = ALU_OR;   srcb_o = SRCB_LUI;  end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over the shared datapath and handshakes with single-port memory.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t state_q;
    logic   req_q;
    logic   rtype_q;
    logic   trap_q;

    logic             funct_legal;
    alu_class_t       alu_cls;
    logic [ALUCW-1:0] alu_ctrl;
    logic [SRCBW-1:0] alu_srcb;

    logic       fetch_want;
    logic       fetch_req;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;

    // Once a fetch request is up it stays up until acked, whatever en does.
    assign fetch_want = (state_q == S_FETCH) && (bus.en || req_q);
    // Reset kills the fetch request combinationally so it drops mid-cycle.
    assign fetch_req  = fetch_want && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            req_q   <= 1'b0;
            rtype_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_want) begin
                        if (bus.mem_ack) begin
                            state_q <= S_DECODE;
                            req_q   <= 1'b0;
                        end else begin
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    rtype_q <= (bus.Op == OP_RTYPE);
                    if (is_load(bus.Op) || is_store(bus.Op)) begin
                        state_q <= S_MEMADR;
                    end else if (bus.Op == OP_RTYPE) begin
                        state_q <= S_RTYPE;
                    end else if ((bus.Op == OP_BEQ) || (bus.Op == OP_BNE)) begin
                        state_q <= S_BRANCH;
                    end else if (bus.Op == OP_J) begin
                        state_q <= S_JUMP;
                    end else if (is_imm(bus.Op)) begin
                        state_q <= S_IMMEX;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end
                end
                S_MEMADR: state_q <= is_load(bus.Op) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (bus.mem_ack) state_q <= S_MEMWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  if (bus.mem_ack) state_q <= S_FETCH;
                S_RTYPE: begin
                    if (funct_legal) begin
                        state_q <= S_ALUWB;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end
                end
                S_IMMEX:  state_q <= S_ALUWB;
                S_ALUWB:  state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        src_a      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_cls    = CLS_IDLE;
        case (state_q)
            S_FETCH: begin
                if (fetch_req) begin
                    mem_req  = 1'b1;
                    alu_cls  = CLS_FETCH;
                    ir_write = bus.mem_ack;
                    pc_en    = bus.mem_ack;
                end
            end
            S_DECODE: alu_cls = CLS_DECODE;
            S_MEMADR: begin src_a = 1'b1; alu_cls = CLS_ADDR; end
            S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEMWR:  begin mem_req = 1'b1; mem_write = 1'b1; iord = 1'b1; end
            S_RTYPE:  begin src_a = 1'b1; alu_cls = CLS_RTYPE; end
            S_IMMEX:  begin src_a = 1'b1; alu_cls = CLS_IMMEX; end
            S_ALUWB:  begin reg_write = 1'b1; reg_dst = rtype_q; end
            S_BRANCH: begin
                src_a   = 1'b1;
                alu_cls = CLS_BRANCH;
                pc_src  = PCSRC_ALUOUT;
                pc_en   = (bus.Op == OP_BEQ) ? bus.Zero : !bus.Zero;
            end
            S_JUMP:   begin pc_src = PCSRC_JUMP; pc_en = 1'b1; end
            default:  ;
        endcase
    end

    mips_alu_sel u_alu_sel (
        .cls_i         (alu_cls),
        .op_i          (bus.Op),
        .funct_i       (bus.Funct),
        .alu_ctrl_o    (alu_ctrl),
        .srcb_o        (alu_srcb),
        .funct_legal_o (funct_legal)
    );

    assign bus.mem_req    = mem_req;
    assign bus.MemWrite   = mem_write;
    assign bus.IorD       = iord;
    assign bus.IRWrite    = ir_write;
    assign bus.PCEn       = pc_en;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = alu_srcb;
    assign bus.ALUControl = alu_ctrl;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.trap       = trap_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl: per-instruction
// expectations from a behavioural model, compared by an output monitor.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cycles;
        int         irw;
        int         dec;
        int         regw;
        logic       regdst;
        logic       m2r;
        int         memw;
        int         memw_bad;
        int         pcen;
        logic [1:0] pcsrc;
        logic [5:0] alu;
        logic [2:0] srcb;
        int         fetch_bad;
        logic       trap;
    } rec_t;

    rec_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic [5:0] legal_ops [21] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                   6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21,
                                   6'h23, 6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2b};
    logic [5:0] legal_fn [8] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: latency, writeback behaviour and ALU setup per class.
    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic zero, input int fd, input int md);
        rec_t r;
        int   base;
        logic taken;
        r      = '{default: 0};
        base   = fd + 1;
        r.irw  = 1;
        r.dec  = 1;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b: begin
                        r.cycles = base + 3; r.regw = 1; r.regdst = 1'b1;
                        r.alu = fn; r.srcb = 3'd0;
                    end
                    default: begin r.trap = 1'b1; r.cycles = base + 2; end
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
                r.cycles = base + 2 + (md + 1) + 1; r.regw = 1; r.m2r = 1'b1;
                r.alu = 6'h20; r.srcb = 3'd2;
            end
            6'h28, 6'h29, 6'h2b: begin
                r.cycles = base + 2 + (md + 1); r.memw = md + 1;
                r.alu = 6'h20; r.srcb = 3'd2;
            end
            6'h04, 6'h05: begin
                r.cycles = base + 2;
                taken    = (op == 6'h04) ? zero : !zero;
                r.pcen   = taken ? 1 : 0;
                r.pcsrc  = taken ? 2'b01 : 2'b00;
                r.alu    = 6'h22; r.srcb = 3'd0;
            end
            6'h02: begin r.cycles = base + 2; r.pcen = 1; r.pcsrc = 2'b10; end
            6'h08: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h20; r.srcb = 3'd2; end
            6'h09: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h21; r.srcb = 3'd2; end
            6'h0a: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h2a; r.srcb = 3'd2; end
            6'h0b: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h2b; r.srcb = 3'd2; end
            6'h0c: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h24; r.srcb = 3'd3; end
            6'h0d: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h25; r.srcb = 3'd3; end
            6'h0e: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h26; r.srcb = 3'd3; end
            6'h0f: begin r.cycles = base + 3; r.regw = 1; r.alu = 6'h25; r.srcb = 3'd4; end
            default: begin r.trap = 1'b1; r.cycles = base + 1; end
        endcase
        return r;
    endfunction

    function automatic logic dut_idle();
        return !bus.mem_req && !bus.MemWrite && !bus.IorD && !bus.IRWrite && !bus.PCEn &&
               (bus.PCSrc == 2'b00) && !bus.ALUSrcA && (bus.ALUSrcB == 3'd0) &&
               (bus.ALUControl == 6'h20) && !bus.RegDst && !bus.MemtoReg &&
               !bus.RegWrite && !bus.trap;
    endfunction

    task automatic compare(input rec_t o);
        rec_t e;
        if (sb.size() == 0) begin
            chk("unexpected_txn", 1, 0);
            return;
        end
        e = sb.pop_front();
        $display("txn op=%02h funct=%02h cycles=%0d trap=%0b regw=%0d memw=%0d pcen=%0d",
                 bus.Op, bus.Funct, o.cycles, o.trap, o.regw, o.memw, o.pcen);
        chk("cycles", o.cycles, e.cycles);
        chk("trap", o.trap, e.trap);
        chk("irwrite", o.irw, e.irw);
        chk("decode_srcb", o.dec, e.dec);
        chk("fetch_outputs", o.fetch_bad, 0);
        if (!e.trap) begin
            chk("regwrite", o.regw, e.regw);
            chk("regdst", o.regdst, e.regdst);
            chk("memtoreg", o.m2r, e.m2r);
            chk("memwrite", o.memw, e.memw);
            chk("memwrite_no_req", o.memw_bad, 0);
            chk("pcen", o.pcen, e.pcen);
            chk("pcsrc", o.pcsrc, e.pcsrc);
            chk("alucontrol", o.alu, e.alu);
            chk("alusrcb", o.srcb, e.srcb);
        end
    endtask

    // Monitor: frames an instruction from first fetch request to return to idle FETCH (or trap).
    initial begin
        rec_t o;
        bit   in_txn  = 1'b0;
        bit   trapped = 1'b0;
        bit   got_alu = 1'b0;
        o = '{default: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                in_txn  = 1'b0;
                trapped = 1'b0;
                continue;
            end
            if (trapped) continue;
            if (!in_txn) begin
                if (bus.mem_req && !bus.IorD) begin
                    in_txn  = 1'b1;
                    got_alu = 1'b0;
                    o       = '{default: 0};
                end else begin
                    continue;
                end
            end
            if (bus.trap) begin
                o.trap  = 1'b1;
                trapped = 1'b1;
                in_txn  = 1'b0;
                compare(o);
            end else if (dut_idle()) begin
                in_txn = 1'b0;
                compare(o);
            end else begin
                o.cycles++;
                if (bus.IRWrite) o.irw++;
                if (bus.ALUSrcB == 3'b101) o.dec++;
                if (bus.RegWrite) begin
                    o.regw++;
                    o.regdst = bus.RegDst;
                    o.m2r    = bus.MemtoReg;
                end
                if (bus.MemWrite) begin
                    if (bus.mem_req && bus.IorD) o.memw++;
                    else o.memw_bad++;
                end
                if (bus.PCEn && !bus.IRWrite) begin
                    o.pcen++;
                    o.pcsrc = bus.PCSrc;
                end
                if (bus.ALUSrcA && !got_alu) begin
                    got_alu = 1'b1;
                    o.alu   = bus.ALUControl;
                    o.srcb  = bus.ALUSrcB;
                end
                if (bus.mem_req && !bus.IorD &&
                    ((bus.ALUSrcB != 3'b001) || (bus.ALUControl != 6'h20) || bus.ALUSrcA))
                    o.fetch_bad++;
                if (bus.IRWrite && (!bus.PCEn || (bus.PCSrc != 2'b00) || !bus.mem_ack))
                    o.fetch_bad++;
            end
        end
    end

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int fd, input int md);
        rec_t e;
        int   cnt      = 0;
        bit   fetched  = 1'b0;
        bit   req_seen = 1'b0;
        bit   done     = 1'b0;
        e = model(op, fn, zero, fd, md);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.Op = op; bus.Funct = fn; bus.Zero = zero; bus.mem_ack = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (fetched)       bus.en = 1'b0;
            else if (req_seen) bus.en = 1'($urandom_range(0, 1));
            else               bus.en = 1'b1;
            #1;
            bus.mem_ack = 1'b0;
            if (bus.trap) begin
                done = 1'b1;
            end else if (fetched && dut_idle()) begin
                done = 1'b1;
            end else if (bus.mem_req) begin
                req_seen = 1'b1;
                if (cnt == (bus.IorD ? md : fd)) begin
                    bus.mem_ack = 1'b1;
                    cnt = 0;
                    if (!bus.IorD) fetched = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
        if (!done) begin
            chk("timeout", 1, 0);
            void'(sb.pop_back());
            @(posedge clk); #3 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0; bus.en = 1'b0; bus.mem_ack = 1'b0;
        end else if (e.trap) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1 bus.en = 1'b1; bus.mem_ack = 1'b0;
                #1;
                chk("trap_hold", bus.trap, 1);
                chk("trap_no_req", bus.mem_req, 0);
            end
            @(posedge clk); #3 reset = 1'b1;
            #1;
            chk("trap_cleared", bus.trap, 0);
            @(posedge clk); #1 reset = 1'b0; bus.en = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        reset = 1'b1;
        bus.en = 1'b0; bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_irwrite", bus.IRWrite, 0);
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_trap", bus.trap, 0);
        chk("rst_alucontrol", bus.ALUControl, 6'h20);
        reset = 1'b0;

        // Reset asserted while a fetch request is outstanding.
        @(posedge clk); #1 bus.en = 1'b1;
        #1 chk("fetch_req_up", bus.mem_req, 1);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("rst_drops_req", bus.mem_req, 0);
        chk("rst_mid_pcen", bus.PCEn, 0);
        chk("rst_mid_trap", bus.trap, 0);
        chk("rst_mid_srcb", bus.ALUSrcB, 0);
        @(posedge clk); #1 reset = 1'b0; bus.en = 1'b0;

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
        run_instr(6'h23, 6'h15, 1'b0, 1, 1);   // LW, one wait in each access
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
        run_instr(6'h2b, 6'h00, 1'b0, 0, 2);   // SW
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'h00, 6'h3f, 1'b0, 1, 0);   // illegal funct

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 99) < 88) ? legal_ops[$urandom_range(0, 20)]
                                              : 6'($urandom);
            fn = ($urandom_range(0, 99) < 88) ? legal_fn[$urandom_range(0, 7)]
                                              : 6'($urandom);
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
